// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parameterised register file and its clear sequencer.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;
    localparam int unsigned DEFAULT_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks every register index once after a request,
// then pulses done for one cycle.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              done,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_idx
);

    clr_state_e        state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (clr_req) begin
                        state_q <= SWEEP;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    idx_q <= idx_q + 1'b1;
                    // All-ones index is the last register; it is cleared on this edge.
                    if (idx_q == '1) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign clr_en  = busy_q;
    assign clr_idx = idx_q;

endmodule

// File: rtl/regfile_param.sv
// Parameterised register file: two combinational read ports, one write port,
// optional hardwired zero register, optional write forwarding and a clear sweep.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src_reg1,
    input  logic [ADDR_W-1:0] src_reg2,
    input  logic [ADDR_W-1:0] dst_reg,
    input  logic              write_reg,
    input  logic [DATA_W-1:0] dst_data,
    output logic [DATA_W-1:0] src_data1,
    output logic [DATA_W-1:0] src_data2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic              clr_en;
    logic [ADDR_W-1:0] clr_idx;

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (clr_busy),
        .done    (clr_done),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );

    logic dst_is_zero;
    logic wr_en;
    logic fwd_ok;

    assign dst_is_zero = ZERO_REG && (dst_reg == '0);
    // Writes arriving while the sweep runs are dropped, not queued.
    assign wr_en       = write_reg && !clr_en && !dst_is_zero;
    assign fwd_ok      = BYPASS && wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else if (clr_en) begin
            regs_q[clr_idx] <= '0;
        end else if (wr_en) begin
            regs_q[dst_reg] <= dst_data;
        end
    end

    logic src1_is_zero;
    logic src2_is_zero;

    assign src1_is_zero = ZERO_REG && (src_reg1 == '0);
    assign src2_is_zero = ZERO_REG && (src_reg2 == '0);

    always_comb begin
        src_data1 = regs_q[src_reg1];
        if (src1_is_zero) begin
            src_data1 = '0;
        end
        if (fwd_ok && (dst_reg == src_reg1)) begin
            src_data1 = dst_data;
        end
    end

    always_comb begin
        src_data2 = regs_q[src_reg2];
        if (src2_is_zero) begin
            src_data2 = '0;
        end
        if (fwd_ok && (dst_reg == src_reg2)) begin
            src_data2 = dst_data;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default, no-forwarding and 32x32 configurations.
module tb_regfile_param;

    logic        clk;
    logic        rst;
    logic [3:0]  src_reg1, src_reg2, dst_reg;
    logic        write_reg, clr_req;
    logic [15:0] dst_data;
    logic [15:0] src_data1, src_data2;
    logic        clr_busy, clr_done;
    logic [15:0] nb_src_data1, nb_src_data2;
    logic        nb_clr_busy, nb_clr_done;

    logic [4:0]  w_src_reg1, w_src_reg2, w_dst_reg;
    logic        w_write_reg, w_clr_req;
    logic [31:0] w_dst_data;
    logic [31:0] w_src_data1, w_src_data2;
    logic        w_clr_busy, w_clr_done;

    int total = 0;
    int bad   = 0;
    int n;
    int cnt;

    regfile_param dut (
        .clk       (clk),
        .rst       (rst),
        .src_reg1  (src_reg1),
        .src_reg2  (src_reg2),
        .dst_reg   (dst_reg),
        .write_reg (write_reg),
        .dst_data  (dst_data),
        .src_data1 (src_data1),
        .src_data2 (src_data2),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    regfile_param #(
        .BYPASS (1'b0)
    ) dut_nb (
        .clk       (clk),
        .rst       (rst),
        .src_reg1  (src_reg1),
        .src_reg2  (src_reg2),
        .dst_reg   (dst_reg),
        .write_reg (write_reg),
        .dst_data  (dst_data),
        .src_data1 (nb_src_data1),
        .src_data2 (nb_src_data2),
        .clr_req   (clr_req),
        .clr_busy  (nb_clr_busy),
        .clr_done  (nb_clr_done)
    );

    regfile_param #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut_w (
        .clk       (clk),
        .rst       (rst),
        .src_reg1  (w_src_reg1),
        .src_reg2  (w_src_reg2),
        .dst_reg   (w_dst_reg),
        .write_reg (w_write_reg),
        .dst_data  (w_dst_data),
        .src_data1 (w_src_data1),
        .src_data2 (w_src_data2),
        .clr_req   (w_clr_req),
        .clr_busy  (w_clr_busy),
        .clr_done  (w_clr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        src_reg1 = '0; src_reg2 = '0; dst_reg = '0;
        write_reg = 1'b0; clr_req = 1'b0; dst_data = '0;
        w_src_reg1 = '0; w_src_reg2 = '0; w_dst_reg = '0;
        w_write_reg = 1'b0; w_clr_req = 1'b0; w_dst_data = '0;
        #1 rst = 1'b1;
        #1;
        src_reg1 = 4'd5; src_reg2 = 4'd15;
        #1;
        check("rst_rd1", src_data1, 0);
        check("rst_rd2", src_data2, 0);
        check("rst_busy", clr_busy, 0);
        check("rst_done", clr_done, 0);
        tick(); tick();
        rst = 1'b0;

        // First edge after reset release must accept the write.
        write_reg = 1'b1; dst_reg = 4'd5; dst_data = 16'hA5A5; src_reg1 = 4'd0;
        tick();
        write_reg = 1'b0; src_reg1 = 4'd5; #1;
        check("r5_read", src_data1, 16'hA5A5);
        check("r5_read_nb", nb_src_data1, 16'hA5A5);

        write_reg = 1'b1; dst_reg = 4'd0; dst_data = 16'h1234; src_reg2 = 4'd0; #1;
        check("r0_no_fwd", src_data2, 0);
        tick();
        write_reg = 1'b0; src_reg1 = 4'd0; #1;
        check("r0_read", src_data1, 0);
        check("r0_read_nb", nb_src_data1, 0);

        write_reg = 1'b1; dst_reg = 4'd3; dst_data = 16'h1111;
        tick();
        dst_data = 16'h00FF; src_reg1 = 4'd3; src_reg2 = 4'd3; #1;
        check("fwd_rd2", src_data2, 16'h00FF);
        check("fwd_rd1", src_data1, 16'h00FF);
        check("nofwd_rd2", nb_src_data2, 16'h1111);
        tick();
        write_reg = 1'b0; #1;
        check("r3_after", src_data2, 16'h00FF);
        check("r3_after_nb", nb_src_data2, 16'h00FF);

        src_reg1 = 4'd5; src_reg2 = 4'd5; #1;
        check("same_idx1", src_data1, 16'hA5A5);
        check("same_idx2", src_data2, 16'hA5A5);

        for (int i = 1; i < 16; i++) begin
            write_reg = 1'b1; dst_reg = 4'(i); dst_data = 16'(16'h1000 + i);
            tick();
        end
        write_reg = 1'b0; src_reg1 = 4'd9; src_reg2 = 4'd15; #1;
        check("fill_r9", src_data1, 16'h1009);
        check("fill_r15", src_data2, 16'h100F);

        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (clr_busy && n < 40) begin
            n++;
            if (n == 3) clr_req = 1'b1;
            if (n == 4) clr_req = 1'b0;
            if (n == 10) begin
                write_reg = 1'b1; dst_reg = 4'd7; dst_data = 16'hBEEF;
                src_reg1 = 4'd7; src_reg2 = 4'd12; #1;
                check("sweep_no_fwd", src_data1, 0);
                check("sweep_stored", src_data2, 16'h100C);
                check("sweep_busy_nb", nb_clr_busy, 1);
            end
            if (n == 11) write_reg = 1'b0;
            tick();
        end
        write_reg = 1'b0;
        check("sweep_len", n, 16);
        check("done_pulse", clr_done, 1);
        check("done_pulse_nb", nb_clr_done, 1);
        tick();
        check("done_gone", clr_done, 0);
        check("busy_gone", clr_busy, 0);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            src_reg1 = 4'(i); src_reg2 = 4'(15 - i); #1;
            if (src_data1 !== 16'h0 || src_data2 !== 16'h0) cnt++;
        end
        check("all_cleared", cnt, 0);
        src_reg1 = 4'd7; #1;
        check("r7_dropped", src_data1, 0);

        // Reset in the middle of a sweep aborts it with no done pulse.
        write_reg = 1'b1; dst_reg = 4'd9; dst_data = 16'h9999;
        tick();
        dst_reg = 4'd14; dst_data = 16'hEEEE;
        tick();
        write_reg = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (5) tick();
        src_reg1 = 4'd9; src_reg2 = 4'd14; #1;
        check("pre_rst_r9", src_data1, 16'h9999);
        rst = 1'b1; #1;
        check("abort_busy", clr_busy, 0);
        check("abort_done", clr_done, 0);
        check("abort_r9", src_data1, 0);
        check("abort_r14", src_data2, 0);
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clr_done !== 1'b0 || clr_busy !== 1'b0) cnt++;
        end
        check("abort_quiet", cnt, 0);

        // Write on the same edge that starts a sweep, then keep the request held.
        write_reg = 1'b1; dst_reg = 4'd4; dst_data = 16'h4444; clr_req = 1'b1;
        tick();
        write_reg = 1'b0; src_reg1 = 4'd4; #1;
        check("wr_with_req", src_data1, 16'h4444);
        check("held_busy", clr_busy, 1);
        n = 0;
        while (!clr_done && n < 40) begin
            n++;
            tick();
        end
        check("held_len", n, 16);
        check("held_r4", src_data1, 0);
        tick();
        check("held_idle_busy", clr_busy, 0);
        check("held_idle_done", clr_done, 0);
        tick();
        check("held_restart", clr_busy, 1);
        clr_req = 1'b0;
        n = 0;
        while (!clr_done && n < 40) begin
            n++;
            tick();
        end
        check("restart_done", clr_done, 1);
        tick();

        w_write_reg = 1'b1; w_dst_reg = 5'd31; w_dst_data = 32'hDEADBEEF;
        w_src_reg1 = 5'd31; w_src_reg2 = 5'd31; #1;
        check("w_fwd", w_src_data1, 32'hDEADBEEF);
        tick();
        w_write_reg = 1'b0; #1;
        check("w_rd1", w_src_data1, 32'hDEADBEEF);
        check("w_rd2", w_src_data2, 32'hDEADBEEF);
        w_clr_req = 1'b1;
        tick();
        w_clr_req = 1'b0;
        n = 0;
        while (w_clr_busy && n < 80) begin
            n++;
            tick();
        end
        check("w_sweep_len", n, 32);
        check("w_done", w_clr_done, 1);
        check("w_cleared", w_src_data1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter ADDR_W, default 4, register index width; NUM_REGS = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1; 1 means register 0 always reads 0 and ignores writes.
REQ-004 Parameter BYPASS, default 1; 1 enables write-to-read forwarding.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 src_reg1  input  ADDR_W  read port 1 index.
REQ-008 src_reg2  input  ADDR_W  read port 2 index.
REQ-009 dst_reg  input  ADDR_W  write index.
REQ-010 write_reg  input  1  write enable.
REQ-011 dst_data  input  DATA_W  write data.
REQ-012 src_data1  output  DATA_W  read port 1 data, driven, no tristate.
REQ-013 src_data2  output  DATA_W  read port 2 data, driven, no tristate.
REQ-014 clr_req  input  1  request a sweep clearing all registers.
REQ-015 clr_busy  output  1  high while the clear sweep runs.
REQ-016 clr_done  output  1  one-cycle pulse when the sweep completes.

Function
REQ-017 Reads SHALL be combinational: src_dataN = contents of register src_regN in the same cycle.
REQ-018 Write SHALL update register dst_reg with dst_data at the rising edge where write_reg=1 and clr_busy=0.
REQ-019 With ZERO_REG=1, reads of index 0 SHALL return 0 and writes to index 0 SHALL have no effect.
REQ-020 With BYPASS=1, clr_busy=0, write_reg=1, dst_reg==src_regN (and not index 0 when ZERO_REG=1), src_dataN SHALL equal dst_data in that cycle.
REQ-021 With BYPASS=0, a same-cycle read of the register being written SHALL return the old value.
REQ-022 Both read ports SHALL be independent; identical indices return identical data.
REQ-023 Clear FSM states: IDLE, SWEEP, DONE.
REQ-024 IDLE -> SWEEP on a rising edge with clr_req=1; sweep index loaded to 0.
REQ-025 In SWEEP, each rising edge SHALL write 0 to register[idx] and increment idx; after clearing index NUM_REGS-1 the FSM SHALL go to DONE.
REQ-026 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-027 clr_busy SHALL be 1 exactly in SWEEP (NUM_REGS cycles); clr_done SHALL be 1 exactly in DONE.
REQ-028 During SWEEP, write_reg SHALL be ignored (write dropped, not queued) and bypass SHALL be disabled.
REQ-029 During SWEEP, reads SHALL return stored contents (cleared entries read 0).
REQ-030 clr_req in SWEEP or DONE SHALL be ignored; clr_req held high SHALL start a new sweep from IDLE on the next edge.
REQ-031 A write in the same edge that clr_req is sampled in IDLE SHALL complete normally.

Reset
REQ-032 rst=1 SHALL immediately set all registers to 0, FSM to IDLE, idx to 0, clr_busy=0, clr_done=0.
REQ-033 rst asserted mid-sweep SHALL abort the sweep with no clr_done pulse.
REQ-034 First write is accepted on the first rising edge after rst deasserts.

Structure
REQ-035 Shared package regfile_pkg SHALL hold the FSM state enum (IDLE, SWEEP, DONE) and default DATA_W/ADDR_W constants.
REQ-036 Clear FSM and index counter SHALL be the sub-module regfile_clr_fsm, outputting busy, done, clear-enable and clear index.
REQ-037 Storage, write decode, bypass mux and zero-register masking SHALL stay in regfile_param.

Verification
REQ-038 Defaults: write R5=0xA5A5, next cycle read src_reg1=5 -> 0xA5A5; write R0=0x1234 -> read R0 = 0x0000.
REQ-039 BYPASS=1: write_reg=1, dst_reg=3, dst_data=0x00FF, src_reg2=3 same cycle -> src_data2=0x00FF; BYPASS=0 -> old R3 value.
REQ-040 Fill R1..R15 with nonzero, pulse clr_req -> clr_busy high 16 cycles, clr_done high 1 cycle, all reads 0 afterwards.
REQ-041 write_reg=1 to R7=0xBEEF during SWEEP after R7 cleared -> R7 reads 0 after done.
REQ-042 rst pulse at sweep cycle 6 -> clr_busy=0 immediately, no clr_done, all registers 0.
REQ-043 DATA_W=32, ADDR_W=5: write R31=0xDEADBEEF, read both ports at 31 -> 0xDEADBEEF; sweep busy 32 cycles.
